bg_pic_writer: RTL and testbench
================================

Name: bg_pic_writer

Overview:
- Write side of the background-picture path: accepts the HPS byte-download stream for the background image (ioctl index 2) and packs it into 16-bit words.
- Queues the words in a small FIFO and writes them to SDRAM with a we/ready handshake.
- Flags when a complete picture is resident, so the video-side background fetcher can enable the overlay.
- Sits between hps_io and the sdram controller's write port, in the same clock domain as the sdram controller.

Parameters:
ADDR_W, 25, SDRAM byte address width
FIFO_DEPTH, 8, word FIFO entries (power of two, ≥4)
BG_INDEX, 2, ioctl_index value that selects the background download

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high
ioctl_download  in  1  download in progress
ioctl_index  in  8  download target index
ioctl_wr  in  1  byte strobe, one cycle per byte
ioctl_addr  in  ADDR_W  byte address of ioctl_dout
ioctl_dout  in  8  download byte
ioctl_wait  out  1  backpressure to hps_io
sdram_present  in  1  SDRAM module fitted (sdram_sz[2:0]!=0)
mem_addr  out  ADDR_W  word write address, bit0 always 0
mem_din  out  16  write data
mem_we  out  1  write request
mem_ready  in  1  controller accepts the write this cycle
bg_valid  out  1  picture fully written
word_count  out  24  words accepted by memory in the current download
overflow  out  1  sticky: a byte was dropped

Behaviour:
- Reset (async): state IDLE, FIFO empty, pending byte cleared. All outputs 0: mem_we=0, mem_addr=0, mem_din=0, ioctl_wait=0, bg_valid=0, word_count=0, overflow=0.
- Active download = ioctl_download & (ioctl_index==BG_INDEX). Downloads with any other index are ignored entirely; state and bg_valid are unchanged.
- FSM states:
  - IDLE / DONE: rising edge of active download → LOAD. On entry: clear word_count, overflow, bg_valid, pending.
  - LOAD: pack bytes. Falling edge of active download → flush pending → DRAIN.
  - DRAIN: when FIFO empty and mem_we=0 → DONE, with bg_valid <= sdram_present & ~overflow.
  - DONE: holds bg_valid; a new active download → LOAD (bg_valid drops the same cycle).
- Packing (LOAD, on ioctl_wr):
  - Even address: byte held as pending low byte with its word address. If a pending byte already exists, the old one is first pushed as {8'h00, low}.
  - Odd address matching the pending word: push {dout, low}; pending cleared.
  - Odd address, no match: flush any pending as {8'h00, low}, then push {dout, 8'h00} at ioctl_addr & ~1.
  - At most one push per cycle. A flush+push pair takes two cycles; ioctl_wait covers this.
- FIFO:
  - A push when count==FIFO_DEPTH is rejected even if a pop occurs the same cycle. The byte is dropped and overflow is set (sticky until the next LOAD entry).
  - ioctl_wait = (count ≥ FIFO_DEPTH-2) | flush-in-progress. Combinational from registered state.
- Memory handshake:
  - Head entry drives mem_addr/mem_din, with mem_we=1 while FIFO is non-empty.
  - A transfer occurs on mem_we & mem_ready in the same cycle: pop, word_count+1 (saturates at 2^24-1).
  - mem_addr/mem_din must not change while mem_we=1 and mem_ready=0.
- Latency: odd byte at cycle N into an empty FIFO → mem_we=1 at N+2 with that word.
- Reset mid-download: everything is discarded and all outputs return to their reset values; no partial bg_valid.
- Download ending while mem_ready is held low: stays in DRAIN indefinitely, bg_valid=0.

Test Plan:
- Index 2 download of bytes 0x11,0x22,0x33,0x44 at addrs 0..3, mem_ready=1 → writes (0,0x2211),(2,0x4433); word_count=2; bg_valid=1 two cycles after the FIFO empties.
- Odd-length download of 3 bytes AA,BB,CC → last write (2,0x00CC); bg_valid=1.
- mem_ready=0 during 20 bytes, FIFO_DEPTH=8 → ioctl_wait high at count 6; mem_addr/mem_din stable; after release all 10 words written in order, overflow=0.
- Same as previous but ioctl_wr ignores ioctl_wait → overflow=1, bg_valid=0 after drain.
- Index 0 download during DONE → no mem_we, bg_valid stays 1; then sdram_present=0 with a new index 2 download → bg_valid=0 in DONE.
- Assert reset after 3 words of a 16-byte download → mem_we=0 and all outputs 0 the same cycle; a subsequent clean download completes normally.

Source files
------------

// File: rtl/bg_pic_writer.sv
// Background-picture write path: packs the HPS byte download into 16-bit words,
// buffers them in a small FIFO and writes them to SDRAM, flagging a complete picture.
module bg_pic_writer #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int BG_INDEX   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              sdram_present,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              bg_valid,
    output logic [23:0]       word_count,
    output logic              overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_next;
    logic              r_active_d;
    logic              r_pend_valid, w_pend_valid_next;
    logic [WA_W-1:0]   r_pend_addr, w_pend_addr_next;
    logic [7:0]        r_pend_data, w_pend_data_next;
    logic              r_stage_valid, w_stage_valid_next;
    logic [WA_W-1:0]   r_stage_addr, w_stage_addr_next;
    logic [15:0]       r_stage_data, w_stage_data_next;
    logic [WA_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [15:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_mem_we;
    logic [WA_W-1:0]   r_mem_addr;
    logic [15:0]       r_mem_din;
    logic              r_bg_valid;
    logic [23:0]       r_word_count;
    logic              r_overflow;

    logic              w_active, w_rise, w_wr;
    logic [WA_W-1:0]   w_byte_wa;
    logic              w_push, w_push_ok, w_drop, w_xfer, w_avail;
    logic [WA_W-1:0]   w_push_addr;
    logic [15:0]       w_push_data;
    logic [PTR_W-1:0]  w_head_idx;
    logic              w_load_entry, w_done_entry;

    assign w_active   = ioctl_download & (ioctl_index == 8'(BG_INDEX));
    assign w_rise     = w_active & ~r_active_d;
    assign w_wr       = ioctl_wr & w_active;
    assign w_byte_wa  = ioctl_addr[ADDR_W-1:1];
    assign w_push_ok  = w_push & (r_count != CNT_FULL);
    assign w_xfer     = r_mem_we & mem_ready;
    // The presented word stays counted until the controller takes it.
    assign w_avail    = (r_count != {{(CNT_W-1){1'b0}}, w_xfer});
    assign w_head_idx = r_rd_ptr + {{(PTR_W-1){1'b0}}, w_xfer};

    assign ioctl_wait = (r_count >= CNT_HIGH) | r_stage_valid;
    assign mem_we     = r_mem_we;
    assign mem_addr   = {r_mem_addr, 1'b0};
    assign mem_din    = r_mem_din;
    assign bg_valid   = r_bg_valid;
    assign word_count = r_word_count;
    assign overflow   = r_overflow;

    // Next state and byte packing: at most one FIFO push per cycle.
    always_comb begin
        w_state_next       = r_state;
        w_load_entry       = 1'b0;
        w_done_entry       = 1'b0;
        w_push             = 1'b0;
        w_push_addr        = r_pend_addr;
        w_push_data        = {8'h00, r_pend_data};
        w_pend_valid_next  = r_pend_valid;
        w_pend_addr_next   = r_pend_addr;
        w_pend_data_next   = r_pend_data;
        w_stage_valid_next = r_stage_valid;
        w_stage_addr_next  = r_stage_addr;
        w_stage_data_next  = r_stage_data;
        w_drop             = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_rise) begin
                    w_state_next       = S_LOAD;
                    w_load_entry       = 1'b1;
                    w_pend_valid_next  = 1'b0;
                    w_stage_valid_next = 1'b0;
                end else begin
                    w_state_next = r_state;
                end
            end
            S_LOAD: begin
                if (r_stage_valid) begin
                    // Second half of a flush+push pair; a byte arriving now cannot be held.
                    w_push             = 1'b1;
                    w_push_addr        = r_stage_addr;
                    w_push_data        = r_stage_data;
                    w_stage_valid_next = 1'b0;
                    w_drop             = w_wr;
                end else if (w_wr) begin
                    if (!ioctl_addr[0]) begin
                        w_push            = r_pend_valid;
                        w_pend_valid_next = 1'b1;
                        w_pend_addr_next  = w_byte_wa;
                        w_pend_data_next  = ioctl_dout;
                    end else if (r_pend_valid && (r_pend_addr == w_byte_wa)) begin
                        w_push            = 1'b1;
                        w_push_data       = {ioctl_dout, r_pend_data};
                        w_pend_valid_next = 1'b0;
                    end else if (r_pend_valid) begin
                        w_push             = 1'b1;
                        w_pend_valid_next  = 1'b0;
                        w_stage_valid_next = 1'b1;
                        w_stage_addr_next  = w_byte_wa;
                        w_stage_data_next  = {ioctl_dout, 8'h00};
                    end else begin
                        w_push      = 1'b1;
                        w_push_addr = w_byte_wa;
                        w_push_data = {ioctl_dout, 8'h00};
                    end
                end else if (!w_active) begin
                    if (r_pend_valid) begin
                        w_push            = 1'b1;
                        w_pend_valid_next = 1'b0;
                    end else begin
                        w_state_next = S_DRAIN;
                    end
                end else begin
                    w_state_next = S_LOAD;
                end
            end
            S_DRAIN: begin
                if ((r_count == {CNT_W{1'b0}}) && !r_mem_we) begin
                    w_state_next = S_DONE;
                    w_done_entry = 1'b1;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register and download-edge tracker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_active_d <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_active_d <= w_active;
        end
    end

    // Pending low byte and the deferred second word of a flush+push pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_addr   <= {WA_W{1'b0}};
            r_pend_data   <= 8'h00;
            r_stage_valid <= 1'b0;
            r_stage_addr  <= {WA_W{1'b0}};
            r_stage_data  <= 16'h0000;
        end else begin
            r_pend_valid  <= w_pend_valid_next;
            r_pend_addr   <= w_pend_addr_next;
            r_pend_data   <= w_pend_data_next;
            r_stage_valid <= w_stage_valid_next;
            r_stage_addr  <= w_stage_addr_next;
            r_stage_data  <= w_stage_data_next;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_addr[r_wr_ptr] <= w_push_addr;
            r_fifo_data[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            if (w_xfer)    r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            r_count <= r_count + {{(CNT_W-1){1'b0}}, w_push_ok} - {{(CNT_W-1){1'b0}}, w_xfer};
        end
    end

    // Registered write port: reloads only when idle or the current word is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= {WA_W{1'b0}};
            r_mem_din  <= 16'h0000;
        end else if (!r_mem_we || mem_ready) begin
            r_mem_we <= w_avail;
            if (w_avail) begin
                r_mem_addr <= r_fifo_addr[w_head_idx];
                r_mem_din  <= r_fifo_data[w_head_idx];
            end
        end
    end

    // Download status: picture flag, accepted-word counter, sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bg_valid   <= 1'b0;
            r_word_count <= 24'h000000;
            r_overflow   <= 1'b0;
        end else if (w_load_entry) begin
            r_bg_valid   <= 1'b0;
            r_word_count <= 24'h000000;
            r_overflow   <= 1'b0;
        end else begin
            if (w_done_entry) r_bg_valid <= sdram_present & ~r_overflow;
            if (w_xfer && (r_word_count != 24'hFFFFFF)) r_word_count <= r_word_count + 24'h000001;
            if ((w_push && !w_push_ok) || w_drop) r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bg_pic_writer.sv
// Scoreboard bench for bg_pic_writer: random byte downloads, a byte-grouping
// reference model, and a monitor that checks every accepted SDRAM write.
module tb_bg_pic_writer;
    localparam int ADDR_W     = 25;
    localparam int FIFO_DEPTH = 8;
    localparam int BG_INDEX   = 2;
    localparam int LIMIT      = 4000;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              sdram_present;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_we;
    logic              mem_ready;
    logic              bg_valid;
    logic [23:0]       word_count;
    logic              overflow;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] tx_addr[$];
    logic [7:0]        tx_data[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_popped = 0;
    int exp_words = 0;
    int bytes_sent = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int lat_cyc = -1;
    int first_odd_cyc = -1;
    bit lat_arm = 1'b0;
    bit abort = 1'b0;

    bg_pic_writer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .BG_INDEX(BG_INDEX)) dut (
        .clk(clk), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .sdram_present(sdram_present),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_ready(mem_ready),
        .bg_valid(bg_valid), .word_count(word_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int req);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Reference model: bytes at an even address and the very next address form
    // one word; any other byte becomes a word of its own, zero in the other half.
    task automatic build_model(input int keep);
        int  i = 0;
        int  n_out = 0;
        wr_t w;
        exp_words = 0;
        while (i < tx_addr.size()) begin
            if (!tx_addr[i][0] && (i + 1 < tx_addr.size()) && (tx_addr[i+1] == tx_addr[i] + ADDR_W'(1))) begin
                w.addr = tx_addr[i];
                w.data = {tx_data[i+1], tx_data[i]};
                i += 2;
            end else if (!tx_addr[i][0]) begin
                w.addr = tx_addr[i];
                w.data = {8'h00, tx_data[i]};
                i += 1;
            end else begin
                w.addr = tx_addr[i] - ADDR_W'(1);
                w.data = {tx_data[i], 8'h00};
                i += 1;
            end
            if (keep < 0 || n_out < keep) begin
                exp_q.push_back(w);
                exp_words++;
            end
            n_out++;
        end
    endtask

    task automatic set_seq(input int base, input int n, input bit jumps);
        int a = base;
        tx_addr.delete();
        tx_data.delete();
        for (int i = 0; i < n; i++) begin
            tx_addr.push_back(ADDR_W'(a));
            tx_data.push_back(8'($urandom_range(0, 255)));
            if (jumps && ($urandom_range(0, 5) == 0)) a = a + int'($urandom_range(2, 7));
            else a = a + 1;
        end
    endtask

    task automatic do_download(input logic [7:0] idx, input bit honor, input int gap_max, input int keep);
        int t;
        if (idx == 8'(BG_INDEX)) build_model(keep);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bytes_sent = 0;
        for (int i = 0; i < tx_addr.size(); i++) begin
            if (abort) break;
            if (honor) begin
                t = 0;
                while (ioctl_wait && t < LIMIT) begin @(posedge clk); #1; t++; end
                if (t >= LIMIT) begin
                    note_fail("wait_timeout", t, LIMIT - 1);
                    break;
                end
            end
            if (abort) break;
            ioctl_addr = tx_addr[i];
            ioctl_dout = tx_data[i];
            ioctl_wr   = 1'b1;
            if (tx_addr[i][0] && first_odd_cyc < 0) first_odd_cyc = cyc;
            bytes_sent++;
            @(posedge clk); #1;
            ioctl_wr = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || mem_we) && t < LIMIT) begin @(posedge clk); #1; t++; end
        if (t >= LIMIT) note_fail("drain_timeout", exp_q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_din"}, mem_din, 0);
        chk({tag, "_ioctl_wait"}, ioctl_wait, 0);
        chk({tag, "_bg_valid"}, bg_valid, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    // mem_ready driver: always ready, random, or held low.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares accepted writes with the scoreboard and checks stall stability.
    initial begin
        logic              prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic [15:0]       prev_din;
        wr_t               w;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_din   = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_addr_hold", mem_addr, prev_addr);
                    chk("stall_din_hold", mem_din, prev_din);
                end
                if (lat_arm && mem_we) begin
                    lat_cyc = cyc;
                    lat_arm = 1'b0;
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        note_fail("unexpected_write_addr", int'(mem_addr), -1);
                    end else begin
                        w = exp_q.pop_front();
                        chk("write_addr", mem_addr, w.addr);
                        chk("write_data", mem_din, w.data);
                        n_popped++;
                    end
                end
                prev_stall = mem_we && !mem_ready;
                prev_addr  = mem_addr;
                prev_din   = mem_din;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got t=%0t, required finish earlier", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = 8'h00; sdram_present = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Four bytes, always ready; also checks first-write latency.
        set_seq(0, 4, 1'b0);
        tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33; tx_data[3] = 8'h44;
        rdy_mode = 0; first_odd_cyc = -1; lat_arm = 1'b1;
        do_download(8'(BG_INDEX), 1'b1, 0, -1);
        wait_done();
        chk("t1_latency", lat_cyc, first_odd_cyc + 2);
        chk("t1_bg_valid", bg_valid, 1);
        chk("t1_word_count", word_count, 2);
        chk("t1_overflow", overflow, 0);

        // Odd-length download: the last byte becomes a word with zero high byte.
        set_seq(0, 3, 1'b0);
        tx_data[0] = 8'hAA; tx_data[1] = 8'hBB; tx_data[2] = 8'hCC;
        do_download(8'(BG_INDEX), 1'b1, 0, -1);
        wait_done();
        chk("t2_bg_valid", bg_valid, 1);
        chk("t2_word_count", word_count, 2);

        // Memory stalled while a host honouring ioctl_wait sends 20 bytes.
        set_seq(0, 20, 1'b0);
        rdy_mode = 2;
        fork
            do_download(8'(BG_INDEX), 1'b1, 0, -1);
            begin
                repeat (40) @(posedge clk);
                #3;
                chk("t3_bytes_before_wait", bytes_sent, 12);
                chk("t3_ioctl_wait", ioctl_wait, 1);
                chk("t3_mem_we_held", mem_we, 1);
                chk("t3_head_addr", mem_addr, 0);
                chk("t3_head_data", mem_din, {tx_data[1], tx_data[0]});
                rdy_mode = 1;
            end
        join
        wait_done();
        chk("t3_word_count", word_count, 10);
        chk("t3_overflow", overflow, 0);
        chk("t3_bg_valid", bg_valid, 1);

        // Same stall but the host ignores ioctl_wait: only FIFO_DEPTH words survive.
        set_seq(0, 20, 1'b0);
        rdy_mode = 2;
        do_download(8'(BG_INDEX), 1'b0, 0, FIFO_DEPTH);
        chk("t4_overflow_set", overflow, 1);
        rdy_mode = 1;
        wait_done();
        chk("t4_bg_valid", bg_valid, 0);
        chk("t4_overflow_sticky", overflow, 1);
        chk("t4_word_count", word_count, FIFO_DEPTH);

        // Clean picture, then a foreign-index download, then one without SDRAM.
        set_seq(0, 8, 1'b0);
        rdy_mode = 0;
        do_download(8'(BG_INDEX), 1'b1, 1, -1);
        wait_done();
        chk("t5_bg_valid", bg_valid, 1);
        set_seq(0, 6, 1'b0);
        do_download(8'h00, 1'b1, 0, -1);
        repeat (10) begin @(posedge clk); #1; end
        chk("t5_other_index_bg_valid", bg_valid, 1);
        chk("t5_other_index_word_count", word_count, 4);
        sdram_present = 1'b0;
        set_seq(0, 4, 1'b0);
        do_download(8'(BG_INDEX), 1'b1, 0, -1);
        wait_done();
        chk("t5_no_sdram_bg_valid", bg_valid, 0);
        chk("t5_no_sdram_word_count", word_count, 2);
        sdram_present = 1'b1;

        // Reset in the middle of a download, then a clean one.
        set_seq(0, 16, 1'b0);
        rdy_mode = 0; n_popped = 0; abort = 1'b0;
        fork
            do_download(8'(BG_INDEX), 1'b1, 0, -1);
            begin
                int t = 0;
                while (n_popped < 3 && t < 500) begin @(negedge clk); #1; t++; end
                if (t >= 500) note_fail("t6_wait_three_words", n_popped, 3);
                reset = 1'b1;
                #1;
                check_outputs_zero("midreset");
                abort = 1'b1;
                exp_q.delete();
            end
        join
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        abort = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        set_seq(100, 10, 1'b0);
        do_download(8'(BG_INDEX), 1'b1, 0, -1);
        wait_done();
        chk("t6_after_reset_bg_valid", bg_valid, 1);
        chk("t6_after_reset_word_count", word_count, 5);

        // Randomised downloads: random base, length, address jumps, gaps and ready.
        for (int k = 0; k < 8; k++) begin
            set_seq(int'($urandom_range(0, 4000)), int'($urandom_range(1, 24)), 1'b1);
            rdy_mode = int'($urandom_range(0, 1));
            do_download(8'(BG_INDEX), 1'b1, 2, -1);
            wait_done();
            chk("rand_bg_valid", bg_valid, 1);
            chk("rand_overflow", overflow, 0);
            chk("rand_word_count", word_count, exp_words);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
